// File: rtl/mmio_led_pkg.sv
// Shared register map, STATUS layout and address decode for the MMIO LED controller.
package mmio_led_pkg;

    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_MODE   = 32'h0000_0004;
    localparam logic [31:0] OFF_PERIOD = 32'h0000_0008;
    localparam logic [31:0] OFF_TOGGLE = 32'h0000_000C;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0010;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_CNT_LSB   = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DATA,
        SEL_MODE,
        SEL_PERIOD,
        SEL_TOGGLE,
        SEL_STATUS
    } reg_sel_e;

    // Exact 32-bit match only, so unaligned or aliased addresses fall to SEL_NONE.
    function automatic reg_sel_e decode_addr(input logic [31:0] base, input logic [31:0] addr);
        if (addr == base + OFF_DATA)   return SEL_DATA;
        if (addr == base + OFF_MODE)   return SEL_MODE;
        if (addr == base + OFF_PERIOD) return SEL_PERIOD;
        if (addr == base + OFF_TOGGLE) return SEL_TOGGLE;
        if (addr == base + OFF_STATUS) return SEL_STATUS;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink prescaler: down-counter that reloads from period and flips phase on expiry.
module led_blink_timer #(
    parameter int PRESC_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PRESC_W-1:0] period,
    output logic               phase,
    output logic [PRESC_W-1:0] count
);

    logic [PRESC_W-1:0] count_q, count_d;
    logic               phase_q, phase_d;

    // A load wins over expiry in the same cycle; a zero period parks the timer.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (load) begin
            count_d = period;
            phase_d = 1'b0;
        end else if (period == '0) begin
            count_d = '0;
            phase_d = 1'b0;
        end else if (count_q == '0) begin
            count_d = period;
            phase_d = ~phase_q;
        end else begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign count = count_q;

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED controller: static/blink LED channels with toggle and status registers.
module mmio_led_ctrl
    import mmio_led_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          N_LEDS    = 8,
    parameter int          PRESC_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_wr,
    input  logic [31:0]       dmem_waddr,
    input  logic [31:0]       dmem_wdata,
    input  logic              dmem_rd,
    input  logic [31:0]       dmem_raddr,
    output logic [31:0]       dmem_rdata,
    output logic [N_LEDS-1:0] leds
);

    logic [N_LEDS-1:0]  data_q, data_d;
    logic [N_LEDS-1:0]  mode_q, mode_d;
    logic [N_LEDS-1:0]  leds_q, leds_d;
    logic [PRESC_W-1:0] period_q, period_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        status_word;
    logic [PRESC_W-1:0] count;
    logic               phase;
    logic               load;
    reg_sel_e           wsel, rsel;
    logic               unused_wdata;

    assign unused_wdata = ^dmem_wdata;

    assign wsel = dmem_wr ? decode_addr(BASE_ADDR, dmem_waddr) : SEL_NONE;
    assign rsel = decode_addr(BASE_ADDR, dmem_raddr);

    always_comb begin
        status_word                              = '0;
        status_word[STATUS_PHASE_BIT]            = phase;
        status_word[31:STATUS_CNT_LSB]           = 31'(count);
    end

    // Reads sample the _q values, so a same-cycle write is not visible until the next read.
    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        load     = 1'b0;
        unique case (wsel)
            SEL_DATA:   data_d = dmem_wdata[N_LEDS-1:0];
            SEL_MODE:   mode_d = dmem_wdata[N_LEDS-1:0];
            SEL_PERIOD: begin
                period_d = dmem_wdata[PRESC_W-1:0];
                load     = 1'b1;
            end
            SEL_TOGGLE: data_d = data_q ^ dmem_wdata[N_LEDS-1:0];
            default: ;
        endcase

        leds_d = data_q & (~mode_q | {N_LEDS{phase}});

        rdata_d = rdata_q;
        if (dmem_rd) begin
            unique case (rsel)
                SEL_DATA:   rdata_d = 32'(data_q);
                SEL_MODE:   rdata_d = 32'(mode_q);
                SEL_PERIOD: rdata_d = 32'(period_q);
                SEL_STATUS: rdata_d = status_word;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            mode_q   <= '0;
            period_q <= '0;
            leds_q   <= '0;
            rdata_q  <= '0;
        end else begin
            data_q   <= data_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            leds_q   <= leds_d;
            rdata_q  <= rdata_d;
        end
    end

    led_blink_timer #(
        .PRESC_W (PRESC_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .period (period_d),
        .phase  (phase),
        .count  (count)
    );

    assign dmem_rdata = rdata_q;
    assign leds       = leds_q;

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Scoreboard bench for mmio_led_ctrl: cycle model predicts reads and LED drive.
module tb_mmio_led_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, dmem_wr, dmem_rd;
    logic [31:0] dmem_waddr, dmem_wdata, dmem_raddr;
    logic [31:0] dmem_rdata;
    logic [7:0]  leds;

    always #5 clk = ~clk;

    mmio_led_ctrl #(.BASE_ADDR(BASE), .N_LEDS(8), .PRESC_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_wr    (dmem_wr),
        .dmem_waddr (dmem_waddr),
        .dmem_wdata (dmem_wdata),
        .dmem_rd    (dmem_rd),
        .dmem_raddr (dmem_raddr),
        .dmem_rdata (dmem_rdata),
        .leds       (leds)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    string       test_name = "init";
    logic [31:0] exp_q[$];

    logic [7:0]  m_data = '0, m_mode = '0, m_leds = '0;
    logic [23:0] m_period = '0, m_cnt = '0;
    logic        m_phase = 1'b0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h expected %h", test_name, tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == BASE)        return {24'h0, m_data};
        if (a == BASE + 4)    return {24'h0, m_mode};
        if (a == BASE + 8)    return {8'h0, m_period};
        if (a == BASE + 16)   return {7'h0, m_cnt, m_phase};
        return 32'h0;
    endfunction

    // One clock: predict next state from current inputs, clock, compare, release strobes.
    task automatic tick();
        logic [7:0]  nd, nm, nl;
        logic [23:0] np, nc;
        logic        nph;
        logic [31:0] nr;
        bit          pushed;
        pushed = 0;
        if (rst) begin
            nd = '0; nm = '0; np = '0; nc = '0; nph = 1'b0; nl = '0; nr = '0;
        end else begin
            nd = m_data; nm = m_mode; np = m_period;
            if (dmem_wr) begin
                if (dmem_waddr == BASE)      nd = dmem_wdata[7:0];
                if (dmem_waddr == BASE + 4)  nm = dmem_wdata[7:0];
                if (dmem_waddr == BASE + 8)  np = dmem_wdata[23:0];
                if (dmem_waddr == BASE + 12) nd = m_data ^ dmem_wdata[7:0];
            end
            if (dmem_wr && dmem_waddr == BASE + 8) begin
                nc = dmem_wdata[23:0]; nph = 1'b0;
            end else if (m_period == 0) begin
                nc = '0; nph = 1'b0;
            end else if (m_cnt == 0) begin
                nc = m_period; nph = ~m_phase;
            end else begin
                nc = m_cnt - 1; nph = m_phase;
            end
            nl = m_data & (~m_mode | {8{m_phase}});
            nr = m_rdata;
            if (dmem_rd) begin
                nr = m_read(dmem_raddr);
                exp_q.push_back(nr);
                pushed = 1;
            end
        end
        @(posedge clk);
        #1;
        m_data = nd; m_mode = nm; m_period = np; m_cnt = nc; m_phase = nph;
        m_leds = nl; m_rdata = nr;
        if (pushed) chk("rdata", dmem_rdata, exp_q.pop_front());
        else        chk("rd_hold", dmem_rdata, m_rdata);
        chk("leds", {24'h0, leds}, {24'h0, m_leds});
        dmem_wr = 1'b0;
        dmem_rd = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmem_wr = 1'b1; dmem_waddr = a; dmem_wdata = d;
        tick();
    endtask

    task automatic rd(input logic [31:0] a);
        dmem_rd = 1'b1; dmem_raddr = a;
        tick();
    endtask

    initial begin
        bit seen_lo, seen_hi;
        logic [31:0] addrs [8];
        addrs = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 16, BASE + 20, BASE + 1, 32'h200};
        rst = 1'b1; dmem_wr = 1'b0; dmem_rd = 1'b0;
        dmem_waddr = '0; dmem_wdata = '0; dmem_raddr = '0;

        test_name = "reset";
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        chk("rst_leds", {24'h0, leds}, 32'h0);
        chk("rst_rdata", dmem_rdata, 32'h0);

        test_name = "static";
        wr(BASE, 32'h0000_00A5);
        tick();
        chk("leds_a5", {24'h0, leds}, 32'hA5);
        rd(BASE);
        chk("rdata_a5", dmem_rdata, 32'h0000_00A5);
        tick(); tick();

        test_name = "toggle";
        wr(BASE + 12, 32'h0000_000F);
        rd(BASE);
        chk("data_aa", dmem_rdata, 32'h0000_00AA);
        rd(BASE + 12);
        chk("toggle_reads0", dmem_rdata, 32'h0);

        test_name = "upper_bits";
        wr(BASE, 32'hFFFF_FF3C);
        rd(BASE);
        chk("data_3c", dmem_rdata, 32'h3C);

        test_name = "blink";
        wr(BASE + 8, 32'd3);
        wr(BASE + 4, 32'hF0);
        wr(BASE, 32'hFF);
        seen_lo = 0; seen_hi = 0;
        for (int i = 0; i < 20; i++) begin
            rd(BASE + 16);
            if (leds == 8'h0F) seen_lo = 1;
            if (leds == 8'hFF) seen_hi = 1;
        end
        chk("seen_0f", {31'h0, seen_lo}, 32'h1);
        chk("seen_ff", {31'h0, seen_hi}, 32'h1);

        test_name = "period0";
        wr(BASE + 8, 32'd0);
        for (int i = 0; i < 6; i++) rd(BASE + 16);
        chk("status0", dmem_rdata, 32'h0);
        chk("dark", {24'h0, leds}, 32'h0F);

        test_name = "period_rewrite";
        wr(BASE + 8, 32'd3);
        tick(); tick();
        wr(BASE + 8, 32'd5);
        rd(BASE + 16);
        chk("p5_status", dmem_rdata, 32'h0000_000A);
        for (int i = 0; i < 8; i++) rd(BASE + 16);

        test_name = "period1";
        wr(BASE + 8, 32'd1);
        for (int i = 0; i < 10; i++) rd(BASE + 16);

        test_name = "decode";
        wr(BASE + 1, 32'hFF);
        wr(32'h200, 32'hFF);
        wr(BASE + 5, 32'h00);
        wr(BASE + 13, 32'hFF);
        rd(BASE + 20);
        chk("unmapped0", dmem_rdata, 32'h0);
        rd(BASE + 1);
        rd(BASE);
        chk("data_kept", dmem_rdata, 32'hFF);
        rd(BASE + 4);
        tick(); tick();

        test_name = "reset_mid";
        wr(BASE + 8, 32'd3);
        tick();
        rd(BASE);
        rst = 1'b1; dmem_rd = 1'b1; dmem_raddr = BASE;
        dmem_wr = 1'b1; dmem_waddr = BASE; dmem_wdata = 32'h55;
        tick();
        chk("rdata_cleared", dmem_rdata, 32'h0);
        chk("leds_cleared", {24'h0, leds}, 32'h0);
        rd(BASE); rd(BASE + 4); rd(BASE + 8); rd(BASE + 16);

        test_name = "same_cycle_rw";
        wr(BASE, 32'h33);
        dmem_wr = 1'b1; dmem_waddr = BASE; dmem_wdata = 32'hC3;
        dmem_rd = 1'b1; dmem_raddr = BASE;
        tick();
        chk("old_value", dmem_rdata, 32'h33);
        rd(BASE);
        chk("new_value", dmem_rdata, 32'hC3);

        test_name = "random";
        for (int i = 0; i < 400; i++) begin
            dmem_wr    = 1'($urandom_range(0, 1));
            dmem_waddr = addrs[$urandom_range(0, 7)];
            dmem_wdata = (dmem_waddr == BASE + 8) ? 32'($urandom_range(0, 6)) : $urandom;
            dmem_rd    = 1'($urandom_range(0, 1));
            dmem_raddr = addrs[$urandom_range(0, 7)];
            rst        = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
